s_mem_arbiter: RTL
==================

Name: s_mem_arbiter

Overview:
- Arbitrates the single-port 256x8 S-array RAM among the RC4 phases: init fill (req 0), KSA swap (req 1) and PRGA/decrypt (req 2).
- Sits between the phase FSMs and the altsyncram instance inside ksa_top.
- Registered one-hot grant with a lock for atomic read-read-write-write swap sequences.
- Per-requester read-valid tagging for the RAM's fixed read latency.

Parameters:
N_REQ, 3, number of requesters (2..8)
ADDR_W, 8, S-RAM address width
DATA_W, 8, S-RAM data width
MEM_LAT, 1, RAM read latency in cycles (1..3)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  access request per requester
lock  in  N_REQ  hold grant across consecutive accesses
addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
wdata  in  N_REQ*DATA_W  packed write data
wren  in  N_REQ  write enable per requester (0 = read)
gnt  out  N_REQ  registered one-hot grant
rvalid  out  N_REQ  read data valid, one-hot by issuing requester
rdata  out  DATA_W  read data, shared by all requesters (mem_q passthrough)
busy  out  1  a grant is currently held
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_wren  out  1  RAM write enable
mem_q  in  DATA_W  RAM read data

Behaviour:
- Reset (synchronous, active-high):
  - gnt=0, rvalid=0, busy=0.
  - Read-tag pipeline cleared; in-flight reads never report rvalid.
  - Owner is none. Round-robin pointer = 0.
- States:
  - IDLE (no owner): on the first edge with any req bit set, the winner is chosen and gnt goes high in the next cycle.
  - OWN(i): gnt[i]=1, busy=1.
- Access:
  - Each cycle with gnt[i] and req[i] is exactly one RAM access.
  - mem_addr, mem_wdata and mem_wren are combinational muxes of requester i's signals.
  - mem_wren = gnt[i] & req[i] & wren[i].
  - With no owner, or owner's req low: mem_wren=0 and mem_addr=0.
- Read return:
  - A read issued in cycle t (gnt[i]&req[i]&!wren[i]) gives rvalid[i]=1 in cycle t+MEM_LAT, with rdata=mem_q.
  - The tag is a MEM_LAT-deep shift register of one-hot vectors.
  - Reads from different owners may interleave in the pipeline; each is tagged correctly.
- Release, evaluated at each edge in OWN(i):
  - req[i]=0: release.
  - req[i]=1, lock[i]=0 and another req bit set: release after this access (one access per grant when contended).
  - req[i]=1 and lock[i]=1: keep. Lock is unbounded; requesters must drop it.
  - req[i]=1, lock[i]=0 and no other request: keep.
- Handover:
  - On release with other requests pending, the new winner's gnt is asserted in the next cycle. There is no idle bubble, and gnt is never multi-hot.
  - On release with no other requests, return to IDLE; gnt=0 in the next cycle.
- Winner selection (default): fixed priority, lowest index wins. Simultaneous requests go to the lowest set index.
- Requests are level-sensitive. A requester must hold req, addr, wdata and wren stable until it sees gnt. A pulse dropped before grant is lost, with no error.
- lock without req is ignored.

Optional Feature:
- Macro: S_MEM_ARB_RR_EN.
- Defined: round-robin selection.
  - The search starts at index (last_owner+1) mod N_REQ. The pointer updates on every grant.
  - Lock and release rules are unchanged.
  - Guarantees no requester waits more than N_REQ-1 grants when others are unlocked.
- Undefined: fixed priority as above; the pointer register is not synthesized.

Test Plan:
- Reset then idle: reset=1 for 2 cycles then 0, no req -> gnt=0, busy=0, mem_wren=0, mem_addr=0, rvalid=0 throughout.
- Single read/write, MEM_LAT=1:
  - req[0]=1, wren[0]=1, addr=8'h05, wdata=8'hA5 -> gnt[0]=1 next cycle, then mem_wren=1 and mem_addr=8'h05 for one access.
  - Then a read at 8'h05 -> rvalid[0]=1 one cycle later with rdata=8'hA5.
- Locked KSA swap: req[1]=1, lock[1]=1, 4 accesses (rd i, rd j, wr i, wr j) while req[2]=1 is pending -> gnt[1] held all 4 cycles, gnt[2]=1 in the cycle after lock[1] drops, no bubble.
- Simultaneous request:
  - req=3'b111, lock=0 -> fixed priority: grant order 0,0,... while req[0] is held.
  - With S_MEM_ARB_RR_EN: grant order 0,1,2,0, one access each.
- Reset mid-read: read issued by requester 2, reset=1 in the next cycle -> rvalid stays 0, gnt=0 the cycle after reset, busy=0.
- Pipelined reads, MEM_LAT=2: back-to-back reads by requester 0 then 1 across a handover -> rvalid[0] then rvalid[1] on consecutive cycles, each with its matching mem_q.

Source files
------------

// File: rtl/s_mem_arbiter.sv
// ---------------------------------------------------------------------------
// s_mem_arbiter
//
// Purpose:
//   Shares the single-port 256x8 S-array RAM between the RC4 phase FSMs
//   (requester 0 = init fill, 1 = KSA swap, 2 = PRGA/decrypt). It keeps a
//   registered one-hot grant. A lock input holds the grant across an atomic
//   read-read-write-write swap. Each read is tagged with its requester so
//   that rvalid comes back to the right requester after the RAM's fixed
//   read latency.
//
// Configuration macro:
//   S_MEM_ARB_RR_EN  defined   -> round-robin winner selection
//                    undefined -> fixed priority, lowest index wins
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   req        in   [N_REQ]         access request per requester (level)
//   lock       in   [N_REQ]         keep the grant across consecutive accesses
//   addr       in   [N_REQ*ADDR_W]  packed addresses, req i at [i*ADDR_W +: ADDR_W]
//   wdata      in   [N_REQ*DATA_W]  packed write data
//   wren       in   [N_REQ]         write enable per requester (0 = read)
//   gnt        out  [N_REQ]         registered one-hot grant
//   rvalid     out  [N_REQ]         read data valid, one-hot by issuing requester
//   rdata      out  [DATA_W]        read data (mem_q passthrough)
//   busy       out                  a grant is currently held
//   mem_addr   out  [ADDR_W]        RAM address
//   mem_wdata  out  [DATA_W]        RAM write data
//   mem_wren   out                  RAM write enable
//   mem_q      in   [DATA_W]        RAM read data
// ---------------------------------------------------------------------------
module s_mem_arbiter #(
   parameter int N_REQ   = 3,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int MEM_LAT = 1
) (
   input  logic                       CLOCK_50,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           lock,
   input  logic [N_REQ*ADDR_W-1:0]    addr,
   input  logic [N_REQ*DATA_W-1:0]    wdata,
   input  logic [N_REQ-1:0]           wren,
   output logic [N_REQ-1:0]           gnt,
   output logic [N_REQ-1:0]           rvalid,
   output logic [DATA_W-1:0]          rdata,
   output logic                       busy,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic                       mem_wren,
   input  logic [DATA_W-1:0]          mem_q
);

   // The grant register is the state: all-zero is IDLE, one-hot i is OWN(i).
   logic [N_REQ-1:0] gnt_q, gnt_d;
   // One-hot read tags, one stage per cycle of RAM latency.
   logic [N_REQ-1:0] tag_q [MEM_LAT];

   logic [N_REQ-1:0] access;     // owner is requesting this cycle
   logic [N_REQ-1:0] rd_issue;   // owner is reading this cycle
   logic             own_req;
   logic             own_lock;
   logic             others;

   assign access   = gnt_q & req;
   assign rd_issue = access & ~wren;
   assign own_req  = |access;
   assign own_lock = |(access & lock);   // lock only counts while req is high
   assign others   = |(req & ~gnt_q);

`ifdef S_MEM_ARB_RR_EN
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Index where the next search starts, i.e. (last owner + 1) mod N_REQ.
   logic [IDX_W-1:0] ptr_q, ptr_d;

   function automatic logic [N_REQ-1:0] pick(input logic [N_REQ-1:0] cand,
                                             input logic [IDX_W-1:0] start);
      logic [N_REQ-1:0] r;
      logic             found;
      r     = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = int'(start) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && cand[idx]) begin
            r[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return r;
   endfunction
`else
   function automatic logic [N_REQ-1:0] pick(input logic [N_REQ-1:0] cand);
      logic [N_REQ-1:0] r;
      r = '0;
      // Scan downward so the lowest set index is the last one written.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (cand[k]) begin
            r    = '0;
            r[k] = 1'b1;
         end
      end
      return r;
   endfunction
`endif

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // Selecting over the full req vector covers every release case. In IDLE
   // it picks the first winner. If the owner dropped req, the owner's bit is
   // already clear. If the owner is unlocked and contended, it may win again
   // under fixed priority, but under round-robin the search starts past it.
   always_comb begin
      // NOTE: default assignment first so no path leaves gnt_d unassigned (no latch).
      gnt_d = gnt_q;
      if ((gnt_q == '0) || !own_req || (!own_lock && others)) begin
`ifdef S_MEM_ARB_RR_EN
         gnt_d = pick(req, ptr_q);
`else
         gnt_d = pick(req);
`endif
      end
   end

`ifdef S_MEM_ARB_RR_EN
   always_comb begin
      ptr_d = ptr_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_d[i]) ptr_d = (i == N_REQ - 1) ? '0 : IDX_W'(i + 1);
      end
   end
`endif

   // ------------------------------------------------------------------
   // State register and read-tag pipeline
   // ------------------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         gnt_q <= '0;
         // NOTE: the tag shift register is reset so that reads in flight at reset never report rvalid.
         for (int k = 0; k < MEM_LAT; k++) tag_q[k] <= '0;
`ifdef S_MEM_ARB_RR_EN
         ptr_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments, so every stage shifts on the same edge.
         gnt_q    <= gnt_d;
         tag_q[0] <= rd_issue;
         for (int k = 1; k < MEM_LAT; k++) tag_q[k] <= tag_q[k-1];
`ifdef S_MEM_ARB_RR_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // The grant is one-hot, so OR-ing the masked requester fields is a mux.
   // The fields are all zero when the owner is not requesting.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (access[i]) begin
            mem_addr  = mem_addr  | addr[i*ADDR_W +: ADDR_W];
            mem_wdata = mem_wdata | wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign mem_wren = |(access & wren);
   assign gnt      = gnt_q;
   assign busy     = |gnt_q;
   assign rdata    = mem_q;
   // Reset is synchronous, so the last tag stage still holds data during the
   // reset cycle. Masking it here drops a read that returns in that cycle.
   assign rvalid   = reset ? '0 : tag_q[MEM_LAT-1];

endmodule
